// File: rtl/sublime_wave_interp_if.sv
// Phase-word handshake, wave-memory read port and sample output of sublime_wave_interp.
// slave is the interpolator side; master is the NCO/memory/mixer side.
interface sublime_wave_interp_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic [31:0]       wave_addr;
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;

  modport slave (
    input  wave_addr, addr_valid, mem_rdata,
    output addr_ready, mem_addr, mem_rd, sample, sample_valid
  );

  modport master (
    output wave_addr, addr_valid, mem_rdata,
    input  addr_ready, mem_addr, mem_rd, sample, sample_valid
  );
endinterface

// File: rtl/sublime_wave_interp.sv
// Wavetable reader: fetches mem[idx] and mem[idx+1] and linearly interpolates by frac.
// SUBLIME_INTERP_EN enables interpolation; without it the block returns mem[idx] directly.
module sublime_wave_interp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sublime_wave_interp_if.slave bus
);
  localparam int unsigned ProdW = DATA_W + FRAC_W + 2;

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StCap, StMul, StAdd} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        idx_q;
  logic signed [DATA_W-1:0] s0_q;
  logic signed [DATA_W-1:0] sample_q;
  logic signed [DATA_W-1:0] sum_d;
  logic                     sample_valid_q;
  logic                     accept;
  logic                     unused_phase;

  assign accept = bus.addr_valid && (state_q == StIdle);
  // Low phase bits below the fraction never contribute to the result.
  assign unused_phase = ^bus.wave_addr;

`ifdef SUBLIME_INTERP_EN
  logic [FRAC_W-1:0]        frac_q;
  logic signed [DATA_W-1:0] s1_q;
  logic signed [ProdW-1:0]  prod_q;
  logic signed [ProdW-1:0]  prod_d;
  logic signed [ProdW-1:0]  prod_shr;
  logic signed [DATA_W:0]   diff;
  logic signed [FRAC_W:0]   frac_s;

  assign diff     = {s1_q[DATA_W-1], s1_q} - {s0_q[DATA_W-1], s0_q};
  assign frac_s   = {1'b0, frac_q};
  assign prod_d   = ProdW'(diff) * ProdW'(frac_s);
  // Arithmetic shift floors toward -inf; the sum always lands between s0 and s1.
  assign prod_shr = prod_q >>> FRAC_W;
  assign sum_d    = DATA_W'(prod_shr + ProdW'(s0_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frac_q <= '0;
      s1_q   <= '0;
      prod_q <= '0;
    end else begin
      if (accept) frac_q <= bus.wave_addr[31-ADDR_W -: FRAC_W];
      if (state_q == StCap) s1_q <= bus.mem_rdata;
      if (state_q == StMul) prod_q <= prod_d;
    end
  end
`else
  assign sum_d = s0_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.addr_valid) state_d = StRd0;
      StRd0:   state_d = StRd1;
`ifdef SUBLIME_INTERP_EN
      StRd1:   state_d = StCap;
      StCap:   state_d = StMul;
      StMul:   state_d = StAdd;
`else
      StRd1:   state_d = StAdd;
`endif
      StAdd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory port decodes from state and latched idx only.
  always_comb begin
    bus.addr_ready = (state_q == StIdle);
    bus.mem_rd     = 1'b0;
    bus.mem_addr   = '0;
    case (state_q)
      StRd0: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = idx_q;
      end
`ifdef SUBLIME_INTERP_EN
      StRd1: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = idx_q + ADDR_W'(1);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q          <= '0;
      s0_q           <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (accept) idx_q <= bus.wave_addr[31 -: ADDR_W];
      if (state_q == StRd1) s0_q <= bus.mem_rdata;
      if (state_q == StAdd) begin
        sample_q       <= sum_d;
        sample_valid_q <= 1'b1;
      end
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
endmodule

// File: doc/sublime_wave_interp.md
# sublime_wave_interp

Wavetable reader that sits directly downstream of the NCO. It consumes the NCO's 32-bit phase word (`wave_addr`) and fetches two adjacent samples from an external single-port wave memory. It then emits one linearly interpolated signed sample per accepted phase word toward the mixer/output stage.

## Interface
- `ADDR_W`, 10: wave memory address width; table holds 2^ADDR_W samples.
- `FRAC_W`, 8: interpolation fraction width; ADDR_W+FRAC_W ≤ 32.
- `DATA_W`, 16: signed sample width.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wave_addr`  in  32  phase word from NCO.
- `addr_valid`  in  1  wave_addr valid this cycle.
- `addr_ready`  out  1  block can accept a phase word (1 only in IDLE).
- `mem_addr`  out  ADDR_W  wave memory read address.
- `mem_rd`  out  1  wave memory read strobe.
- `mem_rdata`  in  DATA_W  signed read data, valid the cycle after the `mem_rd` cycle (1-cycle latency).
- `sample`  out  DATA_W  signed interpolated sample, held until the next result.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.

## Operation
- Field split: idx = wave_addr[31 -: ADDR_W]; frac = wave_addr[31-ADDR_W -: FRAC_W]; remaining low bits ignored.
- Accept occurs on a rising edge with `addr_valid` & `addr_ready`; idx and frac are latched. When `addr_ready`=0, `addr_valid` is ignored; no queuing.
- FSM states: IDLE, RD0, RD1, CAP, MUL, ADD.
  - IDLE → RD0 on accept.
  - RD0: mem_addr=idx, mem_rd=1 → RD1.
  - RD1: mem_addr=(idx+1) mod 2^ADDR_W, mem_rd=1; s0 ← mem_rdata on exit → CAP.
  - CAP: s1 ← mem_rdata on exit → MUL.
  - MUL: diff = s1−s0 (DATA_W+1 signed); prod ← diff × {0,frac} (signed, DATA_W+FRAC_W+2 bits) → ADD.
  - ADD: sample ← s0 + (prod >>> FRAC_W); sample_valid ← 1 → IDLE.
- Other states drive `mem_rd`=0. `mem_addr` and `mem_rd` decode from state and latched idx only; there is no combinational path from inputs.
- Arithmetic: the shift is arithmetic, so results round toward −∞. The result always lies between s0 and s1, so no saturation is needed. frac=0 yields exactly s0.
- Wrap-around: idx = 2^ADDR_W−1 reads the second sample from address 0.

## Timing
- Reset (rst=0, async) forces: state IDLE, addr_ready=1, mem_rd=0, mem_addr=0, sample=0, sample_valid=0, and internal s0/s1/prod=0.
- Reset asserted mid-transaction aborts it. No sample_valid is produced for the aborted word.
- With accept at edge k, sample_valid is high for the single cycle following edge k+5. This is 5-cycle latency.
- addr_ready returns to 1 after edge k+5, in the same cycle as the sample_valid pulse. A word presented then is accepted at edge k+6. Maximum throughput is 1 sample per 6 clocks.
- sample_valid is never high for two consecutive cycles.

## Configuration
- `SUBLIME_INTERP_EN` defined: full interpolation as above, with 2 reads and 5-cycle latency.
- Undefined: RD1 issues no read, and CAP/MUL are skipped.
  - Sequence is IDLE→RD0→RD1→ADD with prod forced to 0, so sample=mem[idx].
  - 1 read per word; sample_valid follows edge k+3; throughput is 1 per 4 clocks.
  - No multiplier is inferred; ports are unchanged.

## Test plan
Parameters are the defaults (ADDR_W=10, FRAC_W=8, DATA_W=16) with a 1-cycle-latency memory model.

- mem[1]=100, mem[2]=200; wave_addr=32'h00600000 (idx 1, frac 0x80) → sample=150, with sample_valid exactly 5 cycles after accept and reads at addr 1 then 2.
- mem[1]=200, mem[2]=100, same address → sample=150. Also, mem[5]=0, mem[6]=−1 with wave_addr=32'h01600000 → sample=−1 (floor).
- Wrap: mem[1023]=−400, mem[0]=400, wave_addr=32'hFFD00000 (idx 1023, frac 0x40) → mem_addr sequence 1023 then 0, sample=−200.
- Handshake: addr_valid held high with wave_addr changing every cycle → a word is accepted every 6 clocks, addr_ready=0 in RD0..ADD, and words offered while busy are dropped.
- Reset: drive rst=0 while in CAP → mem_rd and sample_valid go 0 immediately, sample=0, and addr_ready=1 after release. The next word (frac=0, mem[idx]=1234) → sample=1234.
- Macro undefined: rerun the first scenario → sample=100, sample_valid 3 cycles after accept, and exactly one mem_rd pulse.
